// File: rtl/nr_sqrt_unit.sv
// Iterative unsigned integer square root, non-restoring, STEPS_PER_CYCLE root bits per clock.
// Optional fractional root bits are produced by appending zero radicand pairs.
module nr_sqrt_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FRAC_BITS       = 0,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             clk_en_i,
  input  logic                             valid_entry_i,
  output logic                             ready_o,
  input  logic [DATA_WIDTH-1:0]            radicand_i,
  output logic [DATA_WIDTH/2+FRAC_BITS-1:0] root_o,
  output logic [DATA_WIDTH/2+FRAC_BITS:0]   remainder_o,
  output logic                             data_valid_o,
  input  logic                             result_ack_i
);

  localparam int unsigned ROOT_W = DATA_WIDTH / 2 + FRAC_BITS;
  localparam int unsigned CYCLES = ROOT_W / STEPS_PER_CYCLE;
  localparam int unsigned CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Signed partial remainder width, and a wider scratch width so 4R + pair never wraps.
  localparam int unsigned RW     = ROOT_W + 2;
  localparam int unsigned WW     = ROOT_W + 4;

  typedef enum logic [1:0] {StIdle, StSqrt, StRestore, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2*ROOT_W-1:0]     rad_q, rad_d;
  logic [ROOT_W-1:0]       q_q, q_d;
  logic [RW-1:0]           r_q, r_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ROOT_W-1:0]       root_q, root_d;
  logic [ROOT_W:0]         rem_q, rem_d;

  logic [2*ROOT_W-1:0]     rad_init;
  logic [2*ROOT_W-1:0]     step_rad;
  logic [ROOT_W-1:0]       step_q;
  logic [WW-1:0]           step_r;
  logic [1:0]              pair;
  logic [RW-1:0]           r_fix;
  logic                    ovf;

  // Chained non-restoring steps, next-state logic and FSM transitions.
  always_comb begin
    state_d  = state_q;
    rad_d    = rad_q;
    q_d      = q_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    root_d   = root_q;
    rem_d    = rem_q;
    ovf      = 1'b0;
    pair     = 2'b00;

    // Radicand left-aligned, fractional zero pairs below it.
    rad_init = '0;
    rad_init[2*ROOT_W-1 -: DATA_WIDTH] = radicand_i;

    step_rad = rad_q;
    step_q   = q_q;
    step_r   = {{2{r_q[RW-1]}}, r_q};
    for (int s = 0; s < int'(STEPS_PER_CYCLE); s++) begin
      pair     = step_rad[2*ROOT_W-1 -: 2];
      step_rad = step_rad << 2;
      if (!step_r[WW-1]) begin
        step_r = (step_r << 2) + WW'(pair) - WW'({step_q, 2'b01});
      end else begin
        step_r = (step_r << 2) + WW'(pair) + WW'({step_q, 2'b11});
      end
      // Result must be representable in RW signed bits.
      if ((step_r[WW-1:RW-1] != '0) && (step_r[WW-1:RW-1] != '1)) ovf = 1'b1;
      step_r = {{2{step_r[RW-1]}}, step_r[RW-1:0]};
      step_q = {step_q[ROOT_W-2:0], ~step_r[WW-1]};
    end

    r_fix = r_q + (r_q[RW-1] ? RW'({q_q, 1'b1}) : '0);

    unique case (state_q)
      StIdle: begin
        if (valid_entry_i) begin
          rad_d   = rad_init;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CNT_W'(CYCLES - 1);
          state_d = StSqrt;
        end
      end
      StSqrt: begin
        rad_d = step_rad;
        q_d   = step_q;
        r_d   = step_r[RW-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StRestore;
      end
      StRestore: begin
        r_d     = r_fix;
        root_d  = q_q;
        rem_d   = r_fix[ROOT_W:0];
        state_d = StDone;
      end
      StDone: begin
        if (result_ack_i) state_d = StIdle;
      end
    endcase
  end

  // State registers; reset wins over the clock enable, which freezes everything else.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      rad_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= CNT_W'(CYCLES - 1);
      root_q  <= '0;
      rem_q   <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      rad_q   <= rad_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  // Partial remainder overflow is a design error.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && clk_en_i && (state_q == StSqrt)) begin
      assert (!ovf);
    end
  end

  assign ready_o      = (state_q == StIdle);
  assign data_valid_o = (state_q == StDone);
  assign root_o       = root_q;
  assign remainder_o  = rem_q;

endmodule

// File: tb/tb_nr_sqrt_unit.sv
// Directed bench: default, fractional and 4-steps-per-cycle instances.
module tb_nr_sqrt_unit;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [31:0] radicand;
  logic [2:0]  valid_v;
  logic [2:0]  ack_v;
  logic        ready0, ready1, ready2;
  logic        dv0, dv1, dv2;
  logic [15:0] root0;
  logic [16:0] rem0;
  logic [23:0] root1;
  logic [24:0] rem1;
  logic [15:0] root2;
  logic [16:0] rem2;

  int tests_run;
  int tests_failed;

  nr_sqrt_unit #(.DATA_WIDTH(32), .FRAC_BITS(0), .STEPS_PER_CYCLE(1)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .valid_entry_i(valid_v[0]),
    .ready_o(ready0), .radicand_i(radicand), .root_o(root0), .remainder_o(rem0),
    .data_valid_o(dv0), .result_ack_i(ack_v[0])
  );

  nr_sqrt_unit #(.DATA_WIDTH(32), .FRAC_BITS(8), .STEPS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .valid_entry_i(valid_v[1]),
    .ready_o(ready1), .radicand_i(radicand), .root_o(root1), .remainder_o(rem1),
    .data_valid_o(dv1), .result_ack_i(ack_v[1])
  );

  nr_sqrt_unit #(.DATA_WIDTH(32), .FRAC_BITS(0), .STEPS_PER_CYCLE(4)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .valid_entry_i(valid_v[2]),
    .ready_o(ready2), .radicand_i(radicand), .root_o(root2), .remainder_o(rem2),
    .data_valid_o(dv2), .result_ack_i(ack_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? ready0 : (sel == 1) ? ready1 : ready2;
  endfunction

  function automatic logic dv_of(input int sel);
    return (sel == 0) ? dv0 : (sel == 1) ? dv1 : dv2;
  endfunction

  // Issue one radicand; lat counts edges from the accept edge (inclusive) to data_valid_o.
  task automatic issue(input int sel, input logic [31:0] rad, input bit do_ack,
                       output logic [23:0] root, output logic [24:0] rem, output int lat);
    int guard;
    guard = 0;
    while (!ready_of(sel) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    radicand = rad;
    valid_v[sel] = 1'b1;
    @(posedge clk); #1;
    valid_v[sel] = 1'b0;
    lat = 1;
    while (!dv_of(sel) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    root = (sel == 0) ? 24'(root0) : (sel == 1) ? root1 : 24'(root2);
    rem  = (sel == 0) ? 25'(rem0)  : (sel == 1) ? rem1  : 25'(rem2);
    if (do_ack) begin
      ack_v[sel] = 1'b1;
      @(posedge clk); #1;
      ack_v[sel] = 1'b0;
    end
  endtask

  task automatic test_reset();
    // Reset must act even with the clock enable low.
    clk_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    clk_en = 1'b1;
    tests_run++;
    if ({ready0, ready1, ready2} !== 3'b111 || {dv0, dv1, dv2} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: ready=%b dv=%b expected ready=111 dv=000",
               {ready0, ready1, ready2}, {dv0, dv1, dv2});
    end
    tests_run++;
    if (root0 !== 16'd0 || rem0 !== 17'd0 || root1 !== 24'd0 || rem1 !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_data: root0=%0d rem0=%0d root1=%0d rem1=%0d expected all 0",
               root0, rem0, root1, rem1);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rads  [4];
    logic [23:0] eroot [4];
    logic [24:0] erem  [4];
    logic [23:0] root;
    logic [24:0] rem;
    int lat;
    rads[0] = 32'd0;          eroot[0] = 24'd0;      erem[0] = 25'd0;
    rads[1] = 32'd144;        eroot[1] = 24'd12;     erem[1] = 25'd0;
    rads[2] = 32'd999999;     eroot[2] = 24'd999;    erem[2] = 25'd1998;
    rads[3] = 32'hFFFF_FFFF;  eroot[3] = 24'hFFFF;   erem[3] = 25'h1FFFE;
    for (int i = 0; i < 4; i++) begin
      issue(0, rads[i], 1'b1, root, rem, lat);
      tests_run++;
      if (root !== eroot[i] || rem !== erem[i]) begin
        tests_failed++;
        $display("FAIL basic_%0d: root=%0d rem=%0d expected root=%0d rem=%0d",
                 rads[i], root, rem, eroot[i], erem[i]);
      end
      tests_run++;
      if (lat !== 18) begin
        tests_failed++;
        $display("FAIL basic_latency_%0d: got %0d expected 18", rads[i], lat);
      end
    end
  endtask

  task automatic test_frac();
    logic [23:0] root;
    logic [24:0] rem;
    int lat;
    issue(1, 32'd2, 1'b1, root, rem, lat);
    tests_run++;
    if (root !== 24'd362 || rem !== 25'd28) begin
      tests_failed++;
      $display("FAIL frac_2: root=%0d rem=%0d expected root=362 rem=28", root, rem);
    end
    tests_run++;
    // 24 root bits at one per cycle.
    if (lat !== 26) begin
      tests_failed++;
      $display("FAIL frac_latency: got %0d expected 26", lat);
    end
  endtask

  task automatic test_steps4();
    logic [23:0] root;
    logic [24:0] rem;
    int lat;
    issue(2, 32'd1000000, 1'b1, root, rem, lat);
    tests_run++;
    if (root !== 24'd1000 || rem !== 25'd0) begin
      tests_failed++;
      $display("FAIL steps4_1e6: root=%0d rem=%0d expected root=1000 rem=0", root, rem);
    end
    tests_run++;
    if (lat !== 6) begin
      tests_failed++;
      $display("FAIL steps4_latency: got %0d expected 6", lat);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] root;
    logic [24:0] rem;
    int lat;
    issue(0, 32'd144, 1'b0, root, rem, lat);
    radicand = 32'd49;
    valid_v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (ready0 !== 1'b0 || dv0 !== 1'b1 || root0 !== 16'd12 || rem0 !== 17'd0) begin
        tests_failed++;
        $display("FAIL hold_%0d: ready=%b dv=%b root=%0d rem=%0d expected ready=0 dv=1 root=12 rem=0",
                 i, ready0, dv0, root0, rem0);
      end
    end
    ack_v[0] = 1'b1;
    @(posedge clk); #1;
    ack_v[0] = 1'b0;
    tests_run++;
    if (ready0 !== 1'b1 || dv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_no_accept: ready=%b dv=%b expected ready=1 dv=0", ready0, dv0);
    end
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    tests_run++;
    if (ready0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_after_ack: ready=%b expected 0", ready0);
    end
    lat = 1;
    while (!dv0 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    tests_run++;
    if (root0 !== 16'd7 || rem0 !== 17'd0 || lat !== 18) begin
      tests_failed++;
      $display("FAIL bp_49: root=%0d rem=%0d lat=%0d expected root=7 rem=0 lat=18",
               root0, rem0, lat);
    end
    ack_v[0] = 1'b1;
    @(posedge clk); #1;
    ack_v[0] = 1'b0;
  endtask

  task automatic test_clk_en();
    logic [31:0] pat;
    int lat;
    int off;
    int i;
    pat = 32'hB4E5_3A9D;
    off = 0;
    i   = 0;
    radicand = 32'd999999;
    valid_v[0] = 1'b1;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    lat = 1;
    while (!dv0 && lat < 300) begin
      clk_en = pat[i % 32];
      if (!clk_en) off++;
      i++;
      @(posedge clk); #1; lat++;
    end
    clk_en = 1'b1;
    tests_run++;
    if (root0 !== 16'd999 || rem0 !== 17'd1998) begin
      tests_failed++;
      $display("FAIL clken_result: root=%0d rem=%0d expected root=999 rem=1998", root0, rem0);
    end
    tests_run++;
    if (lat !== 18 + off) begin
      tests_failed++;
      $display("FAIL clken_latency: got %0d expected %0d", lat, 18 + off);
    end
    // Ack while disabled is ignored.
    clk_en = 1'b0;
    ack_v[0] = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (dv0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL clken_ack_ignored: dv=%b expected 1", dv0);
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    ack_v[0] = 1'b0;
    tests_run++;
    if (dv0 !== 1'b0 || ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL clken_ack: dv=%b ready=%b expected dv=0 ready=1", dv0, ready0);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] root;
    logic [24:0] rem;
    int lat;
    radicand = 32'd999999;
    valid_v[0] = 1'b1;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests_run++;
    if (ready0 !== 1'b1 || dv0 !== 1'b0 || root0 !== 16'd0 || rem0 !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: ready=%b dv=%b root=%0d rem=%0d expected ready=1 dv=0 root=0 rem=0",
               ready0, dv0, root0, rem0);
    end
    issue(0, 32'd49, 1'b1, root, rem, lat);
    tests_run++;
    if (root !== 24'd7 || rem !== 25'd0 || lat !== 18) begin
      tests_failed++;
      $display("FAIL after_reset_49: root=%0d rem=%0d lat=%0d expected root=7 rem=0 lat=18",
               root, rem, lat);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clk_en       = 1'b1;
    radicand     = '0;
    valid_v      = '0;
    ack_v        = '0;
    test_reset();
    test_basic();
    test_frac();
    test_steps4();
    test_backpressure();
    test_clk_en();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nr_sqrt_unit.md
# nr_sqrt_unit

Parametrised iterative unsigned integer square root based on the non-restoring algorithm. It computes up to STEPS_PER_CYCLE root bits per clock and can produce optional fractional root bits. It uses a valid/ready handshake on the input and a hold-until-acknowledged handshake on the output. It replaces the fixed 2-bit-per-cycle integer-only square root in the arithmetic library and sits behind the same issue logic as the iterative divider.

## Interface
Parameters:
- DATA_WIDTH, 32, radicand width; must be even and ≥ 4
- FRAC_BITS, 0, extra fractional root bits (0..DATA_WIDTH); each one consumes two implicit zero radicand bits
- STEPS_PER_CYCLE, 1, root bits resolved per clock; must divide N = DATA_WIDTH/2 + FRAC_BITS
- Derived, not overridable: ROOT_W = DATA_WIDTH/2 + FRAC_BITS; CYCLES = N / STEPS_PER_CYCLE

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  synchronous active-low reset
- clk_en_i  in  1  clock enable; when low, all state, counters and outputs hold
- valid_entry_i  in  1  radicand_i is valid
- ready_o  out  1  unit can accept a radicand (high only in IDLE)
- radicand_i  in  DATA_WIDTH  unsigned radicand
- root_o  out  ROOT_W  floor(sqrt(radicand · 4^FRAC_BITS))
- remainder_o  out  ROOT_W+1  radicand · 4^FRAC_BITS − root², always ≥ 0
- data_valid_o  out  1  result valid; held until acknowledged
- result_ack_i  in  1  consumer takes the result

## Operation
- FSM states: IDLE, SQRT, RESTORE, DONE.
- **IDLE**
  - ready_o = 1.
  - On valid_entry_i & clk_en_i: capture radicand_i, left-aligned with 2·FRAC_BITS zero LSBs appended, into an internal 2·ROOT_W-bit shift register.
  - Clear the partial root and the signed partial remainder (ROOT_W+2 bits, two's complement).
  - Load counter = CYCLES−1 and go to SQRT.
- **SQRT**, per clock, STEPS_PER_CYCLE chained steps. Each step:
  - Shift in the next two radicand MSBs: R' = 4R + pair.
  - If R ≥ 0: R = R' − (4Q + 1).
  - Else: R = R' + (4Q + 3).
  - Then Q = 2Q + (R ≥ 0).
  - Decrement counter each clock. When counter = 0, go to RESTORE.
- **RESTORE**, one clock:
  - If R < 0: R = R + (2Q + 1).
  - Latch Q into root_o and the low ROOT_W+1 bits of R into remainder_o. Go to DONE.
- **DONE**
  - data_valid_o = 1; root_o and remainder_o are stable.
  - On result_ack_i & clk_en_i, go to IDLE. data_valid_o falls the next cycle.
  - The result registers keep their values until the next RESTORE.
- A new radicand is never accepted while in DONE, even if result_ack_i is high in the same cycle. ready_o rises only in the cycle after the ack.
- Arithmetic widths:
  - Partial remainder magnitude never exceeds 2Q+1, so ROOT_W+2 signed bits suffice. No overflow is permitted; an overflow is an assertion failure.
  - The root requires no rounding (truncation only).

## Timing
- Reset (rst_n_i low at a clock edge, regardless of clk_en_i):
  - Next cycle: state = IDLE, ready_o = 1, data_valid_o = 0, root_o = 0, remainder_o = 0, counter = CYCLES−1.
  - An operation in progress is discarded; no partial result is ever flagged valid.
- Latency:
  - Accept edge E0. data_valid_o is high after edge E0 + CYCLES + 1, i.e. CYCLES + 2 cycles after the accept cycle.
  - DATA_WIDTH=32, FRAC_BITS=0, STEPS_PER_CYCLE=1: 18 cycles.
  - Same with STEPS_PER_CYCLE=4: 6 cycles.
- Throughput: one result per CYCLES + 3 cycles when the ack is immediate.
- clk_en_i low for k cycles stretches the latency by exactly k cycles. Inputs presented while clk_en_i is low are ignored.
- valid_entry_i outside IDLE is ignored; the source must hold it until it sees ready_o.
- result_ack_i outside DONE is ignored.

## Test plan
- Defaults (32/0/1), radicand 0 -> root 0, remainder 0, valid after 18 cycles. Radicand 144 -> 12/0. Radicand 999999 -> 999/1998.
- Radicand 0xFFFFFFFF -> root 0xFFFF, remainder 0x1FFFE (maximum remainder width exercised).
- FRAC_BITS=8, radicand 2 -> root 362 (0x16A), remainder 28. Radicand 1000000 with STEPS_PER_CYCLE=4 -> root 1000, remainder 0, valid after 6 cycles.
- Backpressure: hold result_ack_i low for 10 cycles with valid_entry_i high.
  - Outputs stay stable and ready_o stays 0.
  - Ack with valid_entry_i high: no accept that cycle; the next radicand is accepted in the following cycle.
- clk_en_i toggled pseudo-randomly during SQRT -> same result, with latency = 18 + number of disabled cycles.
- rst_n_i pulsed low mid-SQRT -> next cycle all outputs are 0 and ready_o = 1. A new radicand 49 -> root 7, remainder 0 with no stale data_valid_o.
